// File: rtl/muldiv_pkg.sv
// Shared types and decode helpers for the RV32M multiply/divide sequencer.
package muldiv_pkg;

  typedef enum logic [1:0] {IDLE, CALC, DONE} muldiv_state_t;

  typedef enum logic [2:0] {
    F3_MUL    = 3'b000,
    F3_MULH   = 3'b001,
    F3_MULHSU = 3'b010,
    F3_MULHU  = 3'b011,
    F3_DIV    = 3'b100,
    F3_DIVU   = 3'b101,
    F3_REM    = 3'b110,
    F3_REMU   = 3'b111
  } muldiv_op_t;

  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  function automatic logic is_div(input logic [2:0] f3);
    return f3[2];
  endfunction

  // MULH, MULHSU, MULHU return the upper half of the product
  function automatic logic is_high(input logic [2:0] f3);
    return !f3[2] && (f3 != 3'b000);
  endfunction

  function automatic logic is_rem(input logic [2:0] f3);
    return f3[2] && f3[1];
  endfunction

  // rs1 is signed for MUL, MULH, MULHSU, DIV, REM
  function automatic logic signed_a(input logic [2:0] f3);
    return (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
           (f3 == 3'b100) || (f3 == 3'b110);
  endfunction

  // rs2 is signed for MUL, MULH, DIV, REM
  function automatic logic signed_b(input logic [2:0] f3);
    return (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b100) || (f3 == 3'b110);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration of unsigned shift-add multiply or restoring divide.
// The accumulator is shared: multiply uses it as {partial product, multiplier};
// divide packs it as {remainder, quotient/dividend}.
module muldiv_step #(
  parameter int XLEN = 32
) (
  input  logic              div_mode,
  input  logic [2*XLEN-1:0] acc_in,
  input  logic [XLEN-1:0]   op_b,
  output logic [2*XLEN-1:0] acc_out
);

  logic [XLEN:0]   sum;
  logic [XLEN:0]   shifted;
  logic            ge;
  logic [XLEN-1:0] rem_next;

  // Single iteration datapath for both operation classes
  always_comb begin
    sum      = {1'b0, acc_in[2*XLEN-1:XLEN]} + (acc_in[0] ? {1'b0, op_b} : '0);
    shifted  = {acc_in[2*XLEN-1:XLEN], acc_in[XLEN-1]};
    ge       = (shifted >= {1'b0, op_b});
    rem_next = ge ? XLEN'(shifted - {1'b0, op_b}) : shifted[XLEN-1:0];
    if (div_mode) begin
      acc_out = {rem_next, acc_in[XLEN-2:0], ge};
    end else begin
      acc_out = {sum, acc_in[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle RV32M multiply/divide sequencer for the EX stage.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic            flush,
  output logic            stall,
  output logic            busy,
  output logic            result_valid,
  output logic [XLEN-1:0] result
);

  localparam int CNT_W = $clog2(XLEN);
  localparam logic [XLEN-1:0] XMIN = {1'b1, {(XLEN-1){1'b0}}};

  muldiv_state_t     state, next_state;
  muldiv_op_t        op;
  logic [2*XLEN-1:0] acc;
  logic [2*XLEN-1:0] step_out;
  logic [XLEN-1:0]   opb;
  logic              res_neg;
  logic [CNT_W-1:0]  cnt;

  logic              a_sgn, b_sgn, neg_req, div_zero, div_ovf, special;
  logic [XLEN-1:0]   abs_a, abs_b, spec_res;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   div_part, final_res;

  muldiv_step #(.XLEN(XLEN)) u_step (
    .div_mode (is_div(op)),
    .acc_in   (acc),
    .op_b     (opb),
    .acc_out  (step_out)
  );

  // Request decode: operand magnitudes, result sign and divide special cases
  always_comb begin
    a_sgn    = signed_a(funct3) & rs1[XLEN-1];
    b_sgn    = signed_b(funct3) & rs2[XLEN-1];
    abs_a    = a_sgn ? -rs1 : rs1;
    abs_b    = b_sgn ? -rs2 : rs2;
    neg_req  = is_rem(funct3) ? a_sgn : (a_sgn ^ b_sgn);
    div_zero = (rs2 == '0);
    div_ovf  = signed_a(funct3) && (rs1 == XMIN) && (rs2 == '1);
    special  = is_div(funct3) && (div_zero || div_ovf);
    if (is_rem(funct3)) begin
      spec_res = div_zero ? rs1 : '0;
    end else begin
      spec_res = div_zero ? '1 : XMIN;
    end
  end

  // Final result selection with sign correction, taken from the last iteration
  always_comb begin
    prod      = res_neg ? -step_out : step_out;
    div_part  = is_rem(op) ? step_out[2*XLEN-1:XLEN] : step_out[XLEN-1:0];
    final_res = res_neg ? -div_part : div_part;
    if (!is_div(op)) begin
      final_res = is_high(op) ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0];
    end
  end

  // Next-state and stall logic
  always_comb begin
    next_state = state;
    stall      = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid && !flush) begin
          stall      = 1'b1;
          next_state = special ? DONE : CALC;
        end
      end
      CALC: begin
        stall = 1'b1;
        if (flush) begin
          next_state = IDLE;
        end else if (cnt == '0) begin
          next_state = DONE;
        end
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Operand latch, iteration and result registers
  always_ff @(posedge clk) begin
    if (reset) begin
      op           <= F3_MUL;
      acc          <= '0;
      opb          <= '0;
      res_neg      <= 1'b0;
      cnt          <= '0;
      busy         <= 1'b0;
      result_valid <= 1'b0;
      result       <= '0;
    end else begin
      busy         <= (next_state != IDLE);
      result_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid && !flush) begin
            op      <= muldiv_op_t'(funct3);
            res_neg <= neg_req;
            cnt     <= CNT_W'(XLEN-1);
            if (special) begin
              result       <= spec_res;
              result_valid <= 1'b1;
            end else if (is_div(funct3)) begin
              acc <= {{XLEN{1'b0}}, abs_a};
              opb <= abs_b;
            end else begin
              acc <= {{XLEN{1'b0}}, abs_b};
              opb <= abs_a;
            end
          end
        end
        CALC: begin
          if (!flush) begin
            acc <= step_out;
            cnt <= cnt - 1'b1;
            if (cnt == '0) begin
              result       <= final_res;
              result_valid <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed self-checking bench for muldiv_sequencer.
module tb_muldiv_sequencer;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            reset;
  logic            req_valid;
  logic [2:0]      funct3;
  logic [XLEN-1:0] rs1, rs2;
  logic            flush;
  logic            stall, busy, result_valid;
  logic [XLEN-1:0] result;

  int checks = 0;
  int errors = 0;
  int unsigned cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  muldiv_sequencer #(.XLEN(XLEN)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .funct3       (funct3),
    .rs1          (rs1),
    .rs2          (rs2),
    .flush        (flush),
    .stall        (stall),
    .busy         (busy),
    .result_valid (result_valid),
    .result       (result)
  );

  // Issue one op, scramble inputs after acceptance, return observed result,
  // latency in cycles, number of stall cycles and whether result_valid lingers.
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat, output int nstall,
                        output logic extra);
    res = '0; lat = -1; nstall = 0; extra = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b1; funct3 = f3; rs1 = a; rs2 = b; flush = 1'b0;
    #1;
    for (int c = 0; c < 60; c++) begin
      if (stall) nstall++;
      if (result_valid) begin
        lat = c; res = result;
        break;
      end
      @(posedge clk); #1;
      if (c == 0) begin
        rs1 = 32'h0BAD_F00D; rs2 = 32'h0000_0005; funct3 = ~f3;
      end
      #1;
    end
    @(posedge clk); #1;
    req_valid = 1'b0; funct3 = 3'b000;
    #1;
    extra = result_valid;
  endtask

  task automatic test_reset();
    reset = 1'b1; req_valid = 1'b0; flush = 1'b0; funct3 = 3'b000; rs1 = '0; rs2 = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL reset_rv got %b want 0", result_valid); end
    checks++; if (result !== 32'h0) begin errors++; $display("FAIL reset_result got %h want 00000000", result); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b want 0", stall); end
    reset = 1'b0;
  endtask

  task automatic test_mul();
    logic [31:0] r; int lat, ns; logic ex;
    run_op(3'b000, 32'd7, 32'hFFFF_FFFD, r, lat, ns, ex);
    checks++; if (r !== 32'hFFFF_FFEB) begin errors++; $display("FAIL mul_result got %h want ffffffeb", r); end
    checks++; if (lat !== 33) begin errors++; $display("FAIL mul_latency got %0d want 33", lat); end
    checks++; if (ns !== 33) begin errors++; $display("FAIL mul_stall_cycles got %0d want 33", ns); end
    checks++; if (ex !== 1'b0) begin errors++; $display("FAIL mul_rv_pulse got %b want 0", ex); end
  endtask

  task automatic test_mulh();
    logic [2:0]  f3  [3] = '{3'b011, 3'b001, 3'b010};
    logic [31:0] va  [3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] vb  [3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0002};
    logic [31:0] exp [3] = '{32'hFFFF_FFFE, 32'h0000_0000, 32'hFFFF_FFFF};
    logic [31:0] r; int lat, ns; logic ex;
    for (int i = 0; i < 3; i++) begin
      run_op(f3[i], va[i], vb[i], r, lat, ns, ex);
      checks++; if (r !== exp[i]) begin errors++; $display("FAIL mulh_result[%0d] got %h want %h", i, r, exp[i]); end
      checks++; if (lat !== 33) begin errors++; $display("FAIL mulh_latency[%0d] got %0d want 33", i, lat); end
    end
  endtask

  task automatic test_div();
    logic [2:0]  f3  [4] = '{3'b100, 3'b110, 3'b101, 3'b111};
    logic [31:0] va  [4] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100};
    logic [31:0] vb  [4] = '{32'd2, 32'd2, 32'd7, 32'd7};
    logic [31:0] exp [4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2};
    logic [31:0] r; int lat, ns; logic ex;
    for (int i = 0; i < 4; i++) begin
      run_op(f3[i], va[i], vb[i], r, lat, ns, ex);
      checks++; if (r !== exp[i]) begin errors++; $display("FAIL div_result[%0d] got %h want %h", i, r, exp[i]); end
      checks++; if (lat !== 33) begin errors++; $display("FAIL div_latency[%0d] got %0d want 33", i, lat); end
    end
  endtask

  task automatic test_special();
    logic [2:0]  f3  [6] = '{3'b101, 3'b111, 3'b100, 3'b110, 3'b100, 3'b110};
    logic [31:0] va  [6] = '{32'h1234, 32'h1234, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFF9};
    logic [31:0] vb  [6] = '{32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0};
    logic [31:0] exp [6] = '{32'hFFFF_FFFF, 32'h1234, 32'h8000_0000, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFF9};
    logic [31:0] r; int lat, ns; logic ex;
    for (int i = 0; i < 6; i++) begin
      run_op(f3[i], va[i], vb[i], r, lat, ns, ex);
      checks++; if (r !== exp[i]) begin errors++; $display("FAIL special_result[%0d] got %h want %h", i, r, exp[i]); end
      checks++; if (lat !== 1) begin errors++; $display("FAIL special_latency[%0d] got %0d want 1", i, lat); end
      checks++; if (ns !== 1) begin errors++; $display("FAIL special_stall[%0d] got %0d want 1", i, ns); end
    end
  endtask

  task automatic test_flush();
    logic [31:0] r; int lat, ns; logic ex; int seen; int unsigned t0; logic got;
    run_op(3'b101, 32'd100, 32'd7, r, lat, ns, ex);
    @(posedge clk); #1;
    req_valid = 1'b1; funct3 = 3'b000; rs1 = 32'd5; rs2 = 32'd6; flush = 1'b0;
    #1;
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      if (result_valid) seen++;
      @(posedge clk); #2;
    end
    flush = 1'b1;
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL flush_calc_stall got %b want 1", stall); end
    @(posedge clk); #1;
    flush = 1'b0; funct3 = 3'b000; rs1 = 32'd3; rs2 = 32'd4;
    #1;
    t0 = cyc;
    checks++; if (seen !== 0) begin errors++; $display("FAIL flush_no_rv got %0d pulses want 0", seen); end
    checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL flush_rv got %b want 0", result_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_busy got %b want 0", busy); end
    checks++; if (result !== 32'd14) begin errors++; $display("FAIL flush_result_kept got %h want 0000000e", result); end
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL flush_new_accept_stall got %b want 1", stall); end
    got = 1'b0;
    for (int c = 0; c < 60; c++) begin
      if (result_valid) begin got = 1'b1; break; end
      @(posedge clk); #2;
    end
    checks++; if (got !== 1'b1 || (cyc - t0) !== 33) begin errors++; $display("FAIL flush_new_latency got %0d want 33", cyc - t0); end
    checks++; if (result !== 32'd12) begin errors++; $display("FAIL flush_new_result got %h want 0000000c", result); end
    @(posedge clk); #1; req_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    int pulses;
    @(posedge clk); #1;
    req_valid = 1'b1; funct3 = 3'b000; rs1 = 32'd9; rs2 = 32'd9; flush = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midreset_busy_before got %b want 1", busy); end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; req_valid = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy got %b want 0", busy); end
    checks++; if (result !== 32'h0) begin errors++; $display("FAIL midreset_result got %h want 00000000", result); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL midreset_stall got %b want 0", stall); end
    pulses = 0;
    for (int c = 0; c < 40; c++) begin
      if (result_valid) pulses++;
      @(posedge clk); #2;
    end
    checks++; if (pulses !== 0) begin errors++; $display("FAIL midreset_no_rv got %0d want 0", pulses); end
  endtask

  task automatic test_back_to_back();
    int unsigned t1, t2; logic [31:0] r1, r2; logic g1, g2;
    @(posedge clk); #1;
    req_valid = 1'b1; funct3 = 3'b000; rs1 = 32'd3; rs2 = 32'd4; flush = 1'b0;
    #1;
    g1 = 1'b0; t1 = 0; r1 = '0;
    for (int c = 0; c < 60; c++) begin
      if (result_valid) begin g1 = 1'b1; t1 = cyc; r1 = result; break; end
      @(posedge clk); #2;
    end
    @(posedge clk); #1;
    funct3 = 3'b100; rs1 = 32'hFFFF_FFF9; rs2 = 32'd2;
    #1;
    checks++; if (stall !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL b2b_accept stall=%b busy=%b want 1/0", stall, busy); end
    g2 = 1'b0; t2 = 0; r2 = '0;
    for (int c = 0; c < 60; c++) begin
      if (result_valid) begin g2 = 1'b1; t2 = cyc; r2 = result; break; end
      @(posedge clk); #2;
    end
    @(posedge clk); #1; req_valid = 1'b0;
    checks++; if (g1 !== 1'b1 || r1 !== 32'd12) begin errors++; $display("FAIL b2b_mul got %h want 0000000c", r1); end
    checks++; if (g2 !== 1'b1 || r2 !== 32'hFFFF_FFFD) begin errors++; $display("FAIL b2b_div got %h want fffffffd", r2); end
    checks++; if ((t2 - t1) !== 34) begin errors++; $display("FAIL b2b_spacing got %0d want 34", t2 - t1); end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_mulh();
    test_div();
    test_special();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
